// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage for model_fifo_ext: synchronous write, asynchronous read.
// Contents are never reset; only the pointers in the parent give them meaning.
module fifo_ram_sdp #(
  parameter int WIDTH  = 8,
  parameter int WIDTHU = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WIDTHU-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTHU-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**WIDTHU];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/model_fifo_ext.sv
// Synchronous single-clock FIFO with look-ahead or registered read data,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module model_fifo_ext #(
  parameter int WIDTH        = 8,
  parameter int WIDTHU       = 4,
  parameter int SHOWAHEAD    = 1,
  parameter int AFULL_LEVEL  = 2**WIDTHU - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              wrreq,
  input  logic [WIDTH-1:0]  data,
  input  logic              rdreq,
  output logic [WIDTH-1:0]  q,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [WIDTHU:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**WIDTHU;
  localparam logic [WIDTHU:0]   DEPTH_CNT  = (WIDTHU+1)'(DEPTH);
  localparam logic [WIDTHU:0]   AFULL_CNT  = (WIDTHU+1)'(AFULL_LEVEL);
  localparam logic [WIDTHU:0]   AEMPTY_CNT = (WIDTHU+1)'(AEMPTY_LEVEL);
  localparam logic [WIDTHU:0]   CNT_ONE    = (WIDTHU+1)'(1);
  localparam logic [WIDTHU-1:0] PTR_ONE    = WIDTHU'(1);

  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("model_fifo_ext: AFULL_LEVEL %0d outside 1..%0d", AFULL_LEVEL, DEPTH);
  end
  if (AEMPTY_LEVEL < 1 || AEMPTY_LEVEL > DEPTH) begin : g_bad_aempty
    $error("model_fifo_ext: AEMPTY_LEVEL %0d outside 1..%0d", AEMPTY_LEVEL, DEPTH);
  end

  logic [WIDTHU-1:0] rd_ptr;
  logic [WIDTHU-1:0] wr_ptr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_ok;
  logic              wr_ok;

  // Flags decode only registered state, so no request input reaches them.
  assign empty        = (usedw == '0);
  assign full         = (usedw == DEPTH_CNT);
  assign almost_full  = (usedw >= AFULL_CNT);
  assign almost_empty = (usedw < AEMPTY_CNT);

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_ok = rdreq && !empty;
  assign wr_ok = wrreq && (!full || rdreq);

  fifo_ram_sdp #(
    .WIDTH  (WIDTH),
    .WIDTHU (WIDTHU)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && !sclr),
    .waddr (wr_ptr),
    .wdata (data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      usedw     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sclr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      usedw     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + CNT_ONE;
        2'b01:   usedw <= usedw - CNT_ONE;
        default: usedw <= usedw;
      endcase
      if (wrreq && full && !rdreq) overflow  <= 1'b1;
      if (rdreq && empty)          underflow <= 1'b1;
    end
  end

  if (SHOWAHEAD != 0) begin : g_lookahead
    assign q = rd_data;
  end else begin : g_registered
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (sclr)  q <= '0;
      else if (rd_ok) q <= rd_data;
    end
  end

endmodule

// File: tb/tb_model_fifo_ext.sv
// Scoreboard bench for model_fifo_ext: a look-ahead and a registered-q instance
// share one stimulus stream (DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1).
module tb_model_fifo_ext;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;
  logic [7:0] data = '0;

  logic [7:0] q_a, q_r;
  logic       empty_a, full_a, af_a, ae_a, ovf_a, udf_a;
  logic       empty_r, full_r, af_r, ae_r, ovf_r, udf_r;
  logic [2:0] usedw_a, usedw_r;

  model_fifo_ext #(
    .WIDTH(8), .WIDTHU(2), .SHOWAHEAD(1), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q_a), .empty(empty_a), .full(full_a), .almost_full(af_a), .almost_empty(ae_a),
    .usedw(usedw_a), .overflow(ovf_a), .underflow(udf_a)
  );

  model_fifo_ext #(
    .WIDTH(8), .WIDTHU(2), .SHOWAHEAD(0), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)
  ) dut_reg (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q_r), .empty(empty_r), .full(full_r), .almost_full(af_r), .almost_empty(ae_r),
    .usedw(usedw_r), .overflow(ovf_r), .underflow(udf_r)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         cnt = 0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " usedw"},        32'(usedw_a), 32'(cnt));
    chk({tag, " empty"},        32'(empty_a), 32'(cnt == 0));
    chk({tag, " full"},         32'(full_a),  32'(cnt == DEPTH));
    chk({tag, " almost_full"},  32'(af_a),    32'(cnt >= 3));
    chk({tag, " almost_empty"}, 32'(ae_a),    32'(cnt < 1));
    chk({tag, " overflow"},     32'(ovf_a),   32'(m_ovf));
    chk({tag, " underflow"},    32'(udf_a),   32'(m_udf));
    chk({tag, " reg usedw"},    32'(usedw_r), 32'(cnt));
    chk({tag, " reg flags"},    {26'd0, empty_r, full_r, af_r, ae_r, ovf_r, udf_r},
                                {26'd0, 1'(cnt == 0), 1'(cnt == DEPTH), 1'(cnt >= 3),
                                 1'(cnt < 1), m_ovf, m_udf});
  endtask

  // Drive one cycle of requests, update the reference model, check flags after the edge.
  task automatic step(input string tag, input bit wr, input logic [7:0] d,
                      input bit rd, input bit clr);
    bit rd_ok, wr_ok;
    wrreq = wr; data = d; rdreq = rd; sclr = clr;
    if (clr) begin
      cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      exp_q.delete();
    end else begin
      rd_ok = rd && (cnt != 0);
      wr_ok = wr && ((cnt != DEPTH) || rd);
      if (wr && cnt == DEPTH && !rd) m_ovf = 1'b1;
      if (rd && cnt == 0)            m_udf = 1'b1;
      if (wr_ok) exp_q.push_back(d);
      cnt = cnt + int'(wr_ok) - int'(rd_ok);
    end
    @(posedge clk); #1;
    wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
    check_state(tag);
  endtask

  // Monitor: pops the scoreboard whenever the DUT accepts a read.
  logic [7:0] last_val = '0;
  bit         has_last = 1'b0;
  logic [7:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_val = '0;
      has_last = 1'b1;
    end else begin
      if (has_last) chk("q_reg", 32'(q_r), 32'(last_val));
      if (sclr) begin
        last_val = '0;
      end else if (rdreq && !empty_a) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL read_unexpected: got q=%0h expected no accepted read", q_a);
        end else begin
          e = exp_q.pop_front();
          chk("q_ahead", 32'(q_a), 32'(e));
          last_val = e;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    step("w11", 1, 8'h11, 0, 0);
    step("w22", 1, 8'h22, 0, 0);
    step("w33", 1, 8'h33, 0, 0);
    step("w44", 1, 8'h44, 0, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 8'h00, 1, 0);

    step("w11b", 1, 8'h11, 0, 0);
    step("w22b", 1, 8'h22, 0, 0);
    step("w33b", 1, 8'h33, 0, 0);
    step("w44b", 1, 8'h44, 0, 0);
    step("ovf55", 1, 8'h55, 0, 0);
    step("rd_after_ovf", 0, 8'h00, 1, 0);

    step("sclr1", 1, 8'hEE, 1, 1);
    step("w11c", 1, 8'h11, 0, 0);
    step("w22c", 1, 8'h22, 0, 0);
    step("w33c", 1, 8'h33, 0, 0);
    step("w44c", 1, 8'h44, 0, 0);
    for (int i = 0; i < 6; i++) step("rw66_full", 1, 8'h66, 1, 0);
    for (int i = 0; i < 4; i++) step("drain66", 0, 8'h00, 1, 0);

    step("rwA5_empty", 1, 8'hA5, 1, 0);
    chk("showahead_A5", 32'(q_a), 32'h0000_00A5);
    step("rdA5", 0, 8'h00, 1, 0);

    step("w77", 1, 8'h77, 0, 0);
    step("rd77", 0, 8'h00, 1, 0);
    chk("reg_q_77", 32'(q_r), 32'h0000_0077);
    step("idle1", 0, 8'h00, 0, 0);
    step("idle2", 0, 8'h00, 0, 0);
    chk("reg_q_77_hold", 32'(q_r), 32'h0000_0077);

    step("w01", 1, 8'h01, 0, 0);
    step("w02", 1, 8'h02, 0, 0);
    step("w03", 1, 8'h03, 0, 0);
    step("w04", 1, 8'h04, 0, 0);
    step("ovf05", 1, 8'h05, 0, 0);
    step("rd01", 0, 8'h00, 1, 0);
    step("sclr2", 1, 8'hEF, 1, 1);
    step("w99", 1, 8'h99, 0, 0);
    step("rd99", 0, 8'h00, 1, 0);

    step("wC1", 1, 8'hC1, 0, 0);
    step("wC2", 1, 8'hC2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    exp_q.delete();
    check_state("mid_reset");
    chk("mid_reset reg_q", 32'(q_r), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("wBE", 1, 8'hBE, 0, 0);
    step("rdBE", 0, 8'h00, 1, 0);
    step("idle_end", 0, 8'h00, 0, 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/model_fifo_ext.md
MODEL_FIFO_EXT -- requirements
Module: model_fifo_ext

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL provide parameter WIDTHU, default 4, address width; DEPTH = 2**WIDTHU words.
REQ-003 The block SHALL provide parameter SHOWAHEAD, default 1; 1 = look-ahead q, 0 = registered q.
REQ-004 The block SHALL provide parameter AFULL_LEVEL, default DEPTH-2, almost-full threshold, legal range 1..DEPTH.
REQ-005 The block SHALL provide parameter AEMPTY_LEVEL, default 2, almost-empty threshold, legal range 1..DEPTH.
REQ-006 Ports SHALL be: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low; sclr in 1 synchronous clear; wrreq in 1 write request; data in WIDTH write data; rdreq in 1 read request.
REQ-007 Outputs SHALL be: q out WIDTH read data; empty out 1; full out 1; almost_full out 1; almost_empty out 1; usedw out WIDTHU+1 word count; overflow out 1 sticky; underflow out 1 sticky.

Function
REQ-008 Read accepted (rd_ok) SHALL be rdreq && !empty; write accepted (wr_ok) SHALL be wrreq && (!full || rdreq).
REQ-009 On wr_ok, data SHALL be stored at wr_ptr, and wr_ptr SHALL advance by 1 modulo DEPTH.
REQ-010 On rd_ok, rd_ptr SHALL advance by 1 modulo DEPTH.
REQ-011 usedw SHALL be a registered count 0..DEPTH: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-012 full SHALL equal (usedw == DEPTH); empty SHALL equal (usedw == 0); both SHALL be decoded from registered state, with no input-to-flag combinational path.
REQ-013 almost_full SHALL equal (usedw >= AFULL_LEVEL); almost_empty SHALL equal (usedw < AEMPTY_LEVEL).
REQ-014 With SHOWAHEAD=1, q SHALL equal mem[rd_ptr] combinationally; q SHALL be valid whenever empty=0.
REQ-015 With SHOWAHEAD=0, q SHALL be a register loaded with mem[rd_ptr] on rd_ok, one cycle after the request, and SHALL hold otherwise.
REQ-016 A word written in cycle N SHALL make empty=0 in cycle N+1 (no write-to-read bypass).
REQ-017 Simultaneous rdreq+wrreq while empty: the read SHALL be rejected, underflow SHALL set, the write SHALL be accepted, and usedw SHALL become 1.
REQ-018 Simultaneous rdreq+wrreq while full: both SHALL be accepted, full SHALL stay 1, and usedw SHALL stay DEPTH.
REQ-019 overflow SHALL set on wrreq && full && !rdreq and SHALL remain set until sclr or reset.
REQ-020 underflow SHALL set on rdreq && empty and SHALL remain set until sclr or reset.
REQ-021 sclr SHALL have priority over all requests in its cycle: pointers, usedw, overflow, underflow and registered q SHALL go to 0, and requests in that cycle SHALL be ignored.
REQ-022 Memory contents SHALL NOT be reset or cleared.

Reset
REQ-023 rst_n low SHALL asynchronously force rd_ptr=0, wr_ptr=0, usedw=0, overflow=0, underflow=0, and registered q=0.
REQ-024 During and after reset, the outputs SHALL be empty=1, full=0, almost_empty=1, almost_full=0.
REQ-025 Reset asserted mid-transfer SHALL discard all stored words; the first word written after reset SHALL be the first word read.

Structure
REQ-026 No shared package SHALL be required; DEPTH SHALL be a localparam derived from WIDTHU.
REQ-027 Storage SHALL be one sub-module, fifo_ram_sdp (simple dual-port, synchronous write, asynchronous read, parameters WIDTH and WIDTHU).
REQ-028 Illegal AFULL_LEVEL or AEMPTY_LEVEL values SHALL be flagged by an elaboration-time check.

Verification (WIDTH=8, WIDTHU=2, DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1)
REQ-029 Write 0x11,0x22,0x33,0x44 -> usedw steps 1,2,3,4; almost_full=1 at usedw=3; full=1 at usedw=4; reads return 0x11..0x44 in order; empty=1 after.
REQ-030 Full, then wrreq alone with 0x55 -> overflow=1, usedw=4, and the next read returns 0x11.
REQ-031 Empty, then rdreq+wrreq with 0xA5 -> underflow=1, usedw=1; SHOWAHEAD=1: q=0xA5 next cycle.
REQ-032 Full, then rdreq+wrreq with 0x66 over 6 cycles -> full stays 1; wrap-around order is preserved: 0x11,0x22,0x33,0x44,0x66.
REQ-033 SHOWAHEAD=0: write 0x77, rdreq in cycle N -> q=0x77 in cycle N+1 and held while rdreq=0.
REQ-034 Three words stored plus sticky flags set, then sclr (or rst_n pulse) -> usedw=0, empty=1, overflow=0, underflow=0; next write/read pair returns the new word.
